pwm_deadtime: RTL and testbench

- Complementary-output dead-time inserter sitting directly downstream of the PWM modulator.
- Consumes the single-ended pwm_out stream and produces high-side and low-side gate drives.
- Guarantees a programmable dead interval where both gate drives are low on every transition.
- Also provides enable gating and a sticky fault shutdown for half-bridge power stages.

---
 rtl/pwm_deadtime.sv | 114 +++++++++++
 tb/tb_pwm_deadtime.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_deadtime.sv
// Complementary dead-time inserter: turns a single PWM stream into high/low gate
// drives with a guaranteed both-off interval, plus enable gating and sticky fault shutdown.
module pwm_deadtime #(
  parameter int DEAD_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  pwm_in,
  input  logic [DEAD_WIDTH-1:0] dead_time,
  input  logic                  fault,
  input  logic                  fault_clr,
  output logic                  hi_out,
  output logic                  lo_out,
  output logic                  dead_active,
  output logic                  fault_latched
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_DEAD = 2'd1,
    ST_HI   = 2'd2,
    ST_LO   = 2'd3
  } state_e;

  localparam logic [DEAD_WIDTH-1:0] CNT_ONE = DEAD_WIDTH'(1);

  state_e                state_q, state_d;
  logic                  pwm_r_q;
  logic                  target_q, target_d;
  logic [DEAD_WIDTH-1:0] cnt_q, cnt_d;
  logic                  fault_q, fault_d;
  logic                  kill;
  logic [DEAD_WIDTH-1:0] dead_len;

  // A programmed dead time of zero still yields one both-off cycle.
  function automatic logic [DEAD_WIDTH-1:0] sat_dead(input logic [DEAD_WIDTH-1:0] d);
    return (d == '0) ? CNT_ONE : d;
  endfunction

  assign dead_len = sat_dead(dead_time);
  assign kill     = !ena || fault || fault_q;

  always_comb begin
    fault_d = fault_q;
    if (fault)          fault_d = 1'b1;
    else if (fault_clr) fault_d = 1'b0;
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    if (kill) begin
      state_d = ST_OFF;
    end else begin
      unique case (state_q)
        ST_OFF: begin
          state_d  = ST_DEAD;
          target_d = pwm_r_q;
          cnt_d    = dead_len;
        end
        ST_DEAD: begin
          if (pwm_r_q != target_q) begin
            target_d = pwm_r_q;
            cnt_d    = dead_len;
          end else if (cnt_q == CNT_ONE) begin
            state_d = target_q ? ST_HI : ST_LO;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_HI: begin
          if (!pwm_r_q) begin
            state_d  = ST_DEAD;
            target_d = 1'b0;
            cnt_d    = dead_len;
          end
        end
        ST_LO: begin
          if (pwm_r_q) begin
            state_d  = ST_DEAD;
            target_d = 1'b1;
            cnt_d    = dead_len;
          end
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  // Input register stage followed by the FSM state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_OFF;
      pwm_r_q  <= 1'b0;
      target_q <= 1'b0;
      cnt_q    <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pwm_r_q  <= pwm_in;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      fault_q  <= fault_d;
    end
  end

  assign hi_out        = (state_q == ST_HI);
  assign lo_out        = (state_q == ST_LO);
  assign dead_active   = (state_q == ST_DEAD);
  assign fault_latched = fault_q;

endmodule

// File: tb/tb_pwm_deadtime.sv
// Bench for pwm_deadtime: directed scenarios plus randomized traffic, compared
// every cycle against a run-length model of the dead-time rules.
module tb_pwm_deadtime;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic       pwm_in;
  logic [7:0] dead_time;
  logic       fault;
  logic       fault_clr;
  logic       hi_out;
  logic       lo_out;
  logic       dead_active;
  logic       fault_latched;

  pwm_deadtime #(.DEAD_WIDTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .pwm_in       (pwm_in),
    .dead_time    (dead_time),
    .fault        (fault),
    .fault_clr    (fault_clr),
    .hi_out       (hi_out),
    .lo_out       (lo_out),
    .dead_active  (dead_active),
    .fault_latched(fault_latched)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: a drive turns on once the registered PWM value has been
  // seen unchanged on more than Dn consecutive un-killed edges.
  int   m_run  = 0;
  int   m_dn   = 1;
  logic m_pwm  = 1'b0;
  logic m_prev = 1'b0;
  logic m_flt  = 1'b0;
  logic e_hi = 1'b0, e_lo = 1'b0, e_dead = 1'b0;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
  endtask

  task automatic model_edge();
    logic k;
    if (rst) begin
      m_run = 0; m_pwm = 1'b0; m_flt = 1'b0; m_prev = 1'b0; m_dn = 1;
      e_hi = 1'b0; e_lo = 1'b0; e_dead = 1'b0;
    end else begin
      k = !ena || fault || m_flt;
      if (k) begin
        m_run = 0;
      end else begin
        if (m_run == 0 || m_pwm != m_prev) begin
          m_run = 1;
          m_dn  = (dead_time == 8'd0) ? 1 : int'(dead_time);
        end else if (m_run < 100000) begin
          m_run++;
        end
        m_prev = m_pwm;
      end
      e_hi   = (m_run > m_dn) &&  m_prev;
      e_lo   = (m_run > m_dn) && !m_prev;
      e_dead = (m_run >= 1) && (m_run <= m_dn);
      if (fault)          m_flt = 1'b1;
      else if (fault_clr) m_flt = 1'b0;
      m_pwm = pwm_in;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("model_hi", hi_out, e_hi);
    check("model_lo", lo_out, e_lo);
    check("model_dead", dead_active, e_dead);
    check("model_fault", fault_latched, m_flt);
    check("no_overlap", hi_out && lo_out, 1'b0);
  endtask

  initial begin
    int dead_cnt;
    rst = 1'b1; ena = 1'b0; pwm_in = 1'b0; dead_time = 8'd4;
    fault = 1'b0; fault_clr = 1'b0;

    // 1: reset state, then first lo_out after a full dead interval
    step(); step();
    check("rst_hi", hi_out, 1'b0);
    check("rst_lo", lo_out, 1'b0);
    check("rst_dead", dead_active, 1'b0);
    check("rst_fault", fault_latched, 1'b0);
    rst = 1'b0; ena = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      step();
      check("t1_dead", dead_active, k < 4);
      check("t1_lo", lo_out, k == 4);
    end
    step(); step();

    // 2: rising then falling edge latency with dead_time=4
    pwm_in = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      step();
      check("t2r_lo", lo_out, k == 0);
      check("t2r_hi", hi_out, k == 5);
      check("t2r_dead", dead_active, k >= 1 && k <= 4);
    end
    step(); step(); step();
    pwm_in = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      step();
      check("t2f_hi", hi_out, k == 0);
      check("t2f_lo", lo_out, k == 5);
      check("t2f_dead", dead_active, k >= 1 && k <= 4);
    end

    // 3: 3-cycle pulse swallowed with dead_time=6
    dead_time = 8'd6;
    step(); step();
    pwm_in = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      step();
      check("t3_hi", hi_out, 1'b0);
      check("t3_lo", lo_out, k == 0 || k == 10);
      if (k == 2) pwm_in = 1'b0;
    end

    // 4: dead_time=0 behaves as one cycle
    ena = 1'b0; step();
    dead_time = 8'd0; ena = 1'b1;
    step(); step(); step(); step();
    check("t4_lo_steady", lo_out, 1'b1);
    pwm_in = 1'b1;
    dead_cnt = 0;
    for (int k = 0; k <= 2; k++) begin
      step();
      if (dead_active) dead_cnt++;
      check("t4_hi", hi_out, k == 2);
    end
    check("t4_one_dead", dead_cnt == 1, 1'b1);
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 99) < 30) pwm_in = ~pwm_in;
      step();
    end

    // 5: fault shutdown, clear with fault still high, then real clear
    dead_time = 8'd4; pwm_in = 1'b1;
    for (int k = 0; k < 12; k++) step();
    check("t5_hi_before", hi_out, 1'b1);
    fault = 1'b1; step();
    check("t5_hi_killed", hi_out, 1'b0);
    check("t5_latched", fault_latched, 1'b1);
    fault = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t5_stay_off", hi_out || lo_out || dead_active, 1'b0);
      check("t5_sticky", fault_latched, 1'b1);
    end
    fault = 1'b1; fault_clr = 1'b1; step();
    check("t5_fault_wins", fault_latched, 1'b1);
    fault = 1'b0; step();
    check("t5_cleared", fault_latched, 1'b0);
    check("t5_off_at_clear", hi_out || dead_active, 1'b0);
    fault_clr = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      step();
      check("t5_dead", dead_active, k < 4);
      check("t5_hi", hi_out, k == 4);
    end

    // 6: enable drop, pwm toggles while disabled, re-enable targets current pwm
    pwm_in = 1'b0;
    for (int k = 0; k < 8; k++) step();
    check("t6_lo_before", lo_out, 1'b1);
    ena = 1'b0;
    step();
    check("t6_off", hi_out || lo_out || dead_active, 1'b0);
    pwm_in = 1'b1; step();
    pwm_in = 1'b0; step();
    pwm_in = 1'b1; step(); step();
    check("t6_still_off", hi_out || lo_out || dead_active, 1'b0);
    ena = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      step();
      check("t6_dead", dead_active, k < 4);
      check("t6_hi", hi_out, k == 4);
    end

    // Randomized traffic including mid-interval dead_time changes and resets
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 99) < 15) pwm_in = ~pwm_in;
      if ($urandom_range(0, 99) < 5)  dead_time = 8'($urandom_range(0, 7));
      ena       = ($urandom_range(0, 99) >= 5);
      fault     = ($urandom_range(0, 99) < 2);
      fault_clr = ($urandom_range(0, 99) < 10);
      rst       = ($urandom_range(0, 199) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
